// File: rtl/conv_window_3x3.sv
// conv_window_3x3
//
// Turns a raster-order pixel stream (WIDTH x HEIGHT, DWIDTH bits per pixel)
// into zero-padded 3x3 windows, one window per pixel, for the 3x3 MAC array.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   resetn     : asynchronous active-low reset
//   in_data    : input pixel, raster order, row 0 first
//   in_valid   : input qualifier; no backpressure, every beat is consumed
//   out_win    : window, element (dr,dc) at [DWIDTH*(3*dr+dc) +: DWIDTH]
//   out_valid  : out_win / out_row / out_col valid this cycle
//   out_row    : row of the window centre
//   out_col    : column of the window centre
//   frame_done : one-cycle pulse on the last output of a frame
//   busy       : frame in progress (RUN or FLUSH)
//   err        : sticky, in_valid seen while flushing; cleared by reset
//
// Each step pushes one pixel into the window's right column together with
// the same column of the two previous rows, read from two line buffers.
// After step k the window centre is pixel k-(WIDTH+1). Positions outside
// the frame are zeroed on the way out, so stale buffer content never leaks.
module conv_window_3x3 #(
  parameter int DWIDTH = 8,
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 56
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [DWIDTH-1:0]         in_data,
  input  logic                      in_valid,
  output logic [9*DWIDTH-1:0]       out_win,
  output logic                      out_valid,
  output logic [$clog2(HEIGHT)-1:0] out_row,
  output logic [$clog2(WIDTH)-1:0]  out_col,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      err
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int KW = $clog2(WIDTH*HEIGHT + WIDTH + 1);

  localparam logic [KW-1:0] K_FIRST_OUT = KW'(WIDTH + 1);
  localparam logic [KW-1:0] K_LAST_PIX  = KW'(WIDTH*HEIGHT - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(WIDTH*HEIGHT + WIDTH);
  localparam logic [CW-1:0] COL_LAST    = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t            state_reg;
  logic [KW-1:0]     k_reg;       // step counter
  logic [CW-1:0]     wcol_reg;    // line-buffer column used by the next step
  logic [RW-1:0]     prow_reg;    // centre position of the next output
  logic [CW-1:0]     pcol_reg;

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  logic [DWIDTH-1:0] lb0_mem [0:WIDTH-1];
  logic [DWIDTH-1:0] lb1_mem [0:WIDTH-1];
  logic [DWIDTH-1:0] lb0_rd_reg;
  logic [DWIDTH-1:0] lb1_rd_reg;

  logic [DWIDTH-1:0] win_reg  [0:2][0:2];
  logic [DWIDTH-1:0] win_next [0:2][0:2];
  logic [9*DWIDTH-1:0] win_masked;

  logic              step;
  logic              emit;
  logic              last_step;
  logic [DWIDTH-1:0] push_data;
  logic [CW-1:0]     wcol_next;

  always_comb begin
    step      = (state_reg == S_FLUSH) || in_valid;
    push_data = (state_reg == S_FLUSH) ? '0 : in_data;
    emit      = step && (k_reg >= K_FIRST_OUT);
    last_step = (state_reg == S_FLUSH) && (k_reg == K_LAST);
    // A frame always restarts at column 0, whatever column the flush ended on.
    if (last_step || (wcol_reg == COL_LAST)) begin
      wcol_next = '0;
    end else begin
      wcol_next = wcol_reg + CW'(1);
    end
  end

  assign busy = (state_reg != S_IDLE);

  // Shift the window left by one column and append the new column.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shift
      assign win_next[gi][0] = win_reg[gi][1];
      assign win_next[gi][1] = win_reg[gi][2];
    end
  endgenerate
  assign win_next[0][2] = lb1_rd_reg;
  assign win_next[1][2] = lb0_rd_reg;
  assign win_next[2][2] = push_data;

  // Zero padding: any element that falls outside the frame is forced to 0.
  generate
    for (gi = 0; gi < 9; gi++) begin : g_mask
      localparam int DR = gi / 3;
      localparam int DC = gi % 3;
      logic keep;
      always_comb begin
        keep = 1'b1;
        if ((DR == 0) && (prow_reg == '0))     keep = 1'b0;
        if ((DR == 2) && (prow_reg == ROW_LAST)) keep = 1'b0;
        if ((DC == 0) && (pcol_reg == '0))     keep = 1'b0;
        if ((DC == 2) && (pcol_reg == COL_LAST)) keep = 1'b0;
      end
      assign win_masked[gi*DWIDTH +: DWIDTH] = keep ? win_next[DR][DC] : '0;
    end
  endgenerate

  // Line buffers with registered read. The read address is the column of
  // the next step, so the data is already waiting when that step arrives.
  // Read and write columns differ except on the final flush step, where the
  // read feeds rows above the next frame that are always masked.
  always_ff @(posedge clk) begin
    if (step) begin
      lb0_mem[wcol_reg] <= push_data;
      lb1_mem[wcol_reg] <= lb0_rd_reg;
      lb0_rd_reg        <= lb0_mem[wcol_next];
      lb1_rd_reg        <= lb1_mem[wcol_next];
    end
  end

  // Control FSM, window register and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      k_reg      <= '0;
      wcol_reg   <= '0;
      prow_reg   <= '0;
      pcol_reg   <= '0;
      out_win    <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else begin
      out_valid  <= emit;
      frame_done <= last_step;

      if (step) begin
        win_reg  <= win_next;
        wcol_reg <= wcol_next;
      end

      if (emit) begin
        out_win <= win_masked;
        out_row <= prow_reg;
        out_col <= pcol_reg;
        if (last_step) begin
          prow_reg <= '0;
          pcol_reg <= '0;
        end else if (pcol_reg == COL_LAST) begin
          pcol_reg <= '0;
          prow_reg <= prow_reg + RW'(1);
        end else begin
          pcol_reg <= pcol_reg + CW'(1);
        end
      end

      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= S_RUN;
            k_reg     <= KW'(1);
          end
        end
        S_RUN: begin
          if (in_valid) begin
            k_reg <= k_reg + KW'(1);
            if (k_reg == K_LAST_PIX) begin
              state_reg <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // Input beats arriving while flushing are dropped and flagged.
          if (in_valid) begin
            err <= 1'b1;
          end
          if (k_reg == K_LAST) begin
            state_reg <= S_IDLE;
            k_reg     <= '0;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          k_reg     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// Testbench for conv_window_3x3: a 4x4 instance for the directed and random
// frame tests, and a default 56x56 instance for the full-size frame.
module tb_conv_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4x4 instance
  logic        a_resetn;
  logic [7:0]  a_in_data;
  logic        a_in_valid;
  logic [71:0] a_out_win;
  logic        a_out_valid;
  logic [1:0]  a_out_row;
  logic [1:0]  a_out_col;
  logic        a_frame_done;
  logic        a_busy;
  logic        a_err;

  // 56x56 instance
  logic        b_resetn;
  logic [7:0]  b_in_data;
  logic        b_in_valid;
  logic [71:0] b_out_win;
  logic        b_out_valid;
  logic [5:0]  b_out_row;
  logic [5:0]  b_out_col;
  logic        b_frame_done;
  logic        b_busy;
  logic        b_err;

  conv_window_3x3 #(.DWIDTH(8), .WIDTH(4), .HEIGHT(4)) dut_a (
    .clk        (clk),
    .resetn     (a_resetn),
    .in_data    (a_in_data),
    .in_valid   (a_in_valid),
    .out_win    (a_out_win),
    .out_valid  (a_out_valid),
    .out_row    (a_out_row),
    .out_col    (a_out_col),
    .frame_done (a_frame_done),
    .busy       (a_busy),
    .err        (a_err)
  );

  conv_window_3x3 dut_b (
    .clk        (clk),
    .resetn     (b_resetn),
    .in_data    (b_in_data),
    .in_valid   (b_in_valid),
    .out_win    (b_out_win),
    .out_valid  (b_out_valid),
    .out_row    (b_out_row),
    .out_col    (b_out_col),
    .frame_done (b_frame_done),
    .busy       (b_busy),
    .err        (b_err)
  );

  typedef struct {
    logic [71:0] win;
    int          row;
    int          col;
    logic        fd;
    logic        busy;
    int          cyc;
  } mon_t;

  typedef struct {
    int          f;
    int          row;
    int          col;
    logic [71:0] win;
  } vec_t;

  mon_t qa[$];
  mon_t qb[$];
  int   pix [0:1][0:3135];  // frame images used by the reference model
  int   sc  [0:1][0:20];    // cycle at which each step of a 4x4 frame is driven
  mon_t got [0:1][0:15];    // last checked outputs of each 4x4 frame
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(negedge clk) begin
    mon_t m;
    if (a_out_valid === 1'b1) begin
      m.win = a_out_win; m.row = int'(a_out_row); m.col = int'(a_out_col);
      m.fd = a_frame_done; m.busy = a_busy; m.cyc = cyc;
      qa.push_back(m);
    end
  end

  always @(negedge clk) begin
    mon_t m;
    if (b_out_valid === 1'b1) begin
      m.win = b_out_win; m.row = int'(b_out_row); m.col = int'(b_out_col);
      m.fd = b_frame_done; m.busy = b_busy; m.cyc = cyc;
      qb.push_back(m);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: element (dr,dc) is the frame pixel at (r+dr-1, c+dc-1),
  // or 0 when that position lies outside the frame.
  function automatic logic [71:0] exp_win(int f, int w, int h, int r, int c);
    logic [71:0] res = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        int rr = r + dr - 1;
        int cc = c + dc - 1;
        if (rr >= 0 && rr < h && cc >= 0 && cc < w)
          res[8*(3*dr+dc) +: 8] = 8'(pix[f][rr*w+cc]);
      end
    end
    return res;
  endfunction

  function automatic logic [71:0] pack9(input int e[9]);
    logic [71:0] res = '0;
    for (int i = 0; i < 9; i++) res[8*i +: 8] = 8'(e[i]);
    return res;
  endfunction

  // mode 0: continuous, 1: one idle cycle after each pixel, 2: random gaps.
  // err_at selects a flush cycle (0..4) in which in_valid is raised, -1 none.
  task automatic drive_a(input int f, input int mode, input int err_at);
    for (int i = 0; i < 16; i++) begin
      int g;
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 8'(pix[f][i]);
      sc[f][i]   = cyc;
      g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (i == 15) g = 0;
      for (int j = 0; j < g; j++) begin
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_data  = 8'($urandom_range(0, 255));
      end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      a_in_valid   = (j == err_at);
      a_in_data    = 8'hEE;
      sc[f][16+j]  = cyc;
    end
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin
      @(negedge clk);
      a_in_valid = 1'b0;
    end
  endtask

  task automatic check_a(input string name, input int f);
    int fails0 = n_fail;
    for (int i = 0; i < 16; i++) begin
      mon_t m;
      logic [127:0] act, exp;
      if (qa.size() == 0) begin
        chk($sformatf("%s out%0d missing", name, i), 128'(0), 128'(1));
      end else begin
        m = qa.pop_front();
        got[f][i] = m;
        act = {m.win, 8'(m.row), 8'(m.col), m.fd, m.busy, 32'(m.cyc)};
        exp = {exp_win(f, 4, 4, i / 4, i % 4), 8'(i / 4), 8'(i % 4),
               (i == 15), (i != 15), 32'(sc[f][i+5] + 1)};
        chk($sformatf("%s out%0d", name, i), act, exp);
      end
    end
    $display("[TB] %s: 16 outputs compared, %0d bad", name, n_fail - fails0);
  endtask

  vec_t tbl [4];

  initial begin
    int e[9];
    int s0;

    a_resetn = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    b_resetn = 1'b0; b_in_valid = 1'b0; b_in_data = '0;

    e = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    tbl[0] = '{0, 0, 0, pack9(e)};
    e = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    tbl[1] = '{0, 1, 1, pack9(e)};
    e = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    tbl[2] = '{0, 3, 3, pack9(e)};
    e = '{0, 0, 0, 0, 101, 102, 0, 105, 106};
    tbl[3] = '{1, 0, 0, pack9(e)};

    repeat (3) @(negedge clk);
    chk("reset out_valid", a_out_valid, 0);
    chk("reset out_win", a_out_win, 0);
    chk("reset row/col", {a_out_row, a_out_col}, 0);
    chk("reset frame_done", a_frame_done, 0);
    chk("reset busy", a_busy, 0);
    chk("reset err", a_err, 0);
    chk("reset b outputs", {b_out_valid, b_busy, b_err, b_frame_done}, 0);
    a_resetn = 1'b1;
    b_resetn = 1'b1;

    // Ramp frame 1..16, continuous
    for (int i = 0; i < 16; i++) pix[0][i] = i + 1;
    drive_a(0, 0, -1);
    idle_a(3);
    check_a("ramp", 0);
    chk("first out 1 cycle after pixel 6", 128'(got[0][0].cyc), 128'(sc[0][5] + 1));
    chk("ramp busy after frame", a_busy, 0);
    chk("ramp err", a_err, 0);

    // Same frame with in_valid toggling 1-0-1-0
    drive_a(0, 1, -1);
    idle_a(3);
    check_a("toggle", 0);

    // Back-to-back frames 1..16 then 101..116
    for (int i = 0; i < 16; i++) pix[1][i] = 101 + i;
    drive_a(0, 0, -1);
    drive_a(1, 0, -1);
    idle_a(3);
    check_a("b2b f1", 0);
    check_a("b2b f2", 1);
    chk("b2b no extra outputs", 128'(qa.size()), 128'(0));

    for (int t = 0; t < 4; t++)
      chk($sformatf("table win(%0d,%0d) f%0d", tbl[t].row, tbl[t].col, tbl[t].f),
          got[tbl[t].f][tbl[t].row*4 + tbl[t].col].win, tbl[t].win);

    // Random frames with random gaps, single and back-to-back
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) pix[0][i] = int'($urandom_range(0, 255));
      drive_a(0, 2, -1);
      idle_a(3);
      check_a($sformatf("random%0d", n), 0);
    end
    for (int i = 0; i < 16; i++) begin
      pix[0][i] = int'($urandom_range(0, 255));
      pix[1][i] = int'($urandom_range(0, 255));
    end
    drive_a(0, 2, -1);
    drive_a(1, 2, -1);
    idle_a(3);
    check_a("random b2b f1", 0);
    check_a("random b2b f2", 1);

    // in_valid during FLUSH: flagged, dropped, flush unchanged
    for (int i = 0; i < 16; i++) pix[0][i] = i + 1;
    drive_a(0, 0, 2);
    idle_a(3);
    check_a("err frame", 0);
    chk("err set", a_err, 1);
    for (int i = 0; i < 16; i++) pix[0][i] = int'($urandom_range(0, 255));
    drive_a(0, 0, -1);
    idle_a(3);
    check_a("after err", 0);
    chk("err sticky", a_err, 1);

    // Reset in the middle of a frame, after pixel 9
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data  = 8'(i + 1);
    end
    @(negedge clk);
    chk("mid-frame out_valid before reset", a_out_valid, 1);
    a_resetn   = 1'b0;
    a_in_valid = 1'b0;
    #1;
    chk("async reset out_valid", a_out_valid, 0);
    chk("async reset busy", a_busy, 0);
    chk("async reset out_win", a_out_win, 0);
    chk("async reset err", a_err, 0);
    repeat (2) @(negedge clk);
    qa.delete();
    a_resetn = 1'b1;
    for (int i = 0; i < 16; i++) pix[0][i] = int'($urandom_range(0, 255));
    drive_a(0, 0, -1);
    idle_a(3);
    check_a("after reset", 0);
    chk("after reset err", a_err, 0);
    chk("after reset no extra outputs", 128'(qa.size()), 128'(0));

    // Full-size 56x56 frame, pixel = index mod 256
    for (int k = 0; k < 3136; k++) pix[0][k] = k % 256;
    s0 = 0;
    for (int k = 0; k < 3136; k++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = 8'(k % 256);
      if (k == 0) s0 = cyc;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int t = 0; t < 200 && qb.size() < 3136; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("56x56 output count", 128'(qb.size()), 128'(3136));
    begin
      int fails0 = n_fail;
      for (int i = 0; i < 3136 && i < qb.size(); i++) begin
        logic [127:0] act, exp;
        act = {qb[i].win, 8'(qb[i].row), 8'(qb[i].col), qb[i].fd, qb[i].busy, 32'(qb[i].cyc)};
        exp = {exp_win(0, 56, 56, i / 56, i % 56), 8'(i / 56), 8'(i % 56),
               (i == 3135), (i != 3135), 32'(s0 + i + 58)};
        chk($sformatf("56x56 out%0d", i), act, exp);
      end
      $display("[TB] 56x56 frame: %0d outputs compared, %0d bad", qb.size(), n_fail - fails0);
    end
    chk("56x56 err", b_err, 0);
    chk("56x56 busy after frame", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
